register_array_stabilizer_seq: RTL and testbench
================================================

Name: register_array_stabilizer_seq

Overview:
- Parametrised stabilizer-matrix register array: NUM_QUBIT rows of literal and phase vectors, with a command handshake.
- Executes multi-step operations autonomously: shift-down load, N-step literal rotate, N-step phase shift, N-step row rotate, clear.
- Holds a LIFO stack of cofactor positions for nested cofactor emulation.
- Sits between the gate-emulation datapath and the row-processing unit, which reads the bottom row.

Parameters:
- NUM_QUBIT, 4, rows and literal columns.
- MAX_VECTOR, 2**NUM_QUBIT, phase bits per row.
- LIT_W, 2, bits per literal.
- COF_DEPTH, 4, cofactor stack entries (>=2).
- CNT_W, $clog2(MAX_VECTOR)+1, step-count width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high when IDLE
- cmd_op  in  3  0 NOP, 1 SHIFT_DOWN, 2 ROT_LIT, 3 SHIFT_PH, 4 ROT_ROW, 5 CLEAR, 6-7 treated as NOP
- cmd_cnt  in  CNT_W  step count for ops 2/3/4
- literals_in  in  NUM_QUBIT*LIT_W  row for SHIFT_DOWN
- phase_in  in  MAX_VECTOR  phases for SHIFT_DOWN
- phase_right_in  in  NUM_QUBIT  per-row bit entering the right end on each SHIFT_PH step
- literals_out  out  NUM_QUBIT*LIT_W  bottom row (row NUM_QUBIT-1)
- phase_out  out  MAX_VECTOR  bottom row phases
- phase_left_out  out  NUM_QUBIT  phase[row][0] of each row
- done  out  1  one-cycle pulse when a command completes
- cof_push / cof_pop  in  1  stack control
- cof_pos_in  in  32  value to push
- cof_top  out  32  top of stack (0 when empty)
- cof_empty / cof_full  out  1  stack status
- cof_err  out  1  sticky; set on push-when-full or pop-when-empty

Behaviour:
- Reset: all literal and phase registers 0; state IDLE; cmd_ready=1; done=0; stack empty; cof_top=0; cof_err=0.
- FSM states: IDLE, EXEC, DONE.
- IDLE -> EXEC on cmd_valid&&cmd_ready. Capture op and remaining=cmd_cnt; cmd_ready drops the next cycle.
- SHIFT_DOWN, CLEAR, NOP: always one step, regardless of cmd_cnt.
- Ops 2/3/4 with cmd_cnt==0: no register change.
- EXEC: performs one step per cycle, decrementing remaining. Moves to DONE after the final step.
- DONE: done=1 for exactly one cycle, then IDLE. Accept-to-done latency = max(steps,1)+1 cycles.
- SHIFT_DOWN: row0<=inputs; row i<=row i-1; the bottom row is discarded.
- ROT_LIT step: every row's literals rotate left by one column; column0 wraps to column NUM_QUBIT-1. Phases held.
- SHIFT_PH step: every row's phases shift left by one; phase[i][MAX_VECTOR-1]<=phase_right_in[i], sampled each step cycle. Literals held.
- ROT_ROW step: the bottom row (literals and phases) moves to row0; the others shift down by one.
- CLEAR: all literal and phase bits <=0.
- Commands presented while cmd_ready=0 are ignored; the master must hold cmd_valid.
- Cofactor stack is independent of the FSM and operates in any state:
  - push: write cof_pos_in at top.
  - pop: discard top.
  - push and pop in the same cycle, non-empty: replace top, no depth change.
  - push and pop in the same cycle, empty: behaves as push, no error.
  - Full push or empty pop: no state change, cof_err<=1, held until reset.
- Outputs literals_out, phase_out, phase_left_out are combinational from registers. They reflect the state after each step.
- Reset mid-EXEC: immediate return to reset values; no done pulse.

Optional Feature:
- Macro: STAB_ROW_PARITY_EN.
- When defined: adds output row_parity[NUM_QUBIT-1:0], registered XOR of each row's phase bits.
  - Updated one cycle after any register change.
  - Reset 0.
- When undefined: port absent and no parity logic.

Test Plan:
- 4 SHIFT_DOWN with literals 0x01,0x23,0x45,0x67 and phase 0xA5A5 on the first -> bottom row literals 0x01, phase_out 0xA5A5. Each done arrives 2 cycles after accept.
- ROT_LIT cmd_cnt=5 on NUM_QUBIT=4 -> net rotation by 1; done 6 cycles after accept; cmd_ready low throughout.
- SHIFT_PH cmd_cnt=3 with phase_right_in driven 1,0,1 on row 0 -> row0 phase low 3 bits shifted out; top 3 bits = 1,0,1; phase_left_out tracks each step.
- ROT_ROW cmd_cnt=NUM_QUBIT -> matrix unchanged. cmd_cnt=0 -> unchanged, done after 2 cycles.
- Stack COF_DEPTH=4: push 10,20,30,40 -> cof_full=1, cof_top=40. Push 50 -> cof_err=1, cof_top=40. Pop x4 -> empty, cof_top=0. Pop -> cof_err stays 1.
- Assert rst_n low mid-ROT_LIT -> all outputs 0 and cmd_ready=1 without waiting for a clock edge; no done pulse.

Source files
------------

// File: rtl/register_array_stabilizer_seq.sv
// Stabilizer-matrix register array with a multi-step command sequencer and a cofactor LIFO.
// Optional macro STAB_ROW_PARITY_EN adds a registered per-row phase parity output.
module register_array_stabilizer_seq #(
    parameter int NUM_QUBIT  = 4,
    parameter int MAX_VECTOR = 2**NUM_QUBIT,
    parameter int LIT_W      = 2,
    parameter int COF_DEPTH  = 4,
    parameter int CNT_W      = $clog2(MAX_VECTOR) + 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [2:0]                   cmd_op,
    input  logic [CNT_W-1:0]             cmd_cnt,
    input  logic [NUM_QUBIT*LIT_W-1:0]   literals_in,
    input  logic [MAX_VECTOR-1:0]        phase_in,
    input  logic [NUM_QUBIT-1:0]         phase_right_in,
    output logic [NUM_QUBIT*LIT_W-1:0]   literals_out,
    output logic [MAX_VECTOR-1:0]        phase_out,
    output logic [NUM_QUBIT-1:0]         phase_left_out,
    output logic                         done,
    input  logic                         cof_push,
    input  logic                         cof_pop,
    input  logic [31:0]                  cof_pos_in,
    output logic [31:0]                  cof_top,
    output logic                         cof_empty,
    output logic                         cof_full,
    output logic                         cof_err
`ifdef STAB_ROW_PARITY_EN
    ,
    output logic [NUM_QUBIT-1:0]         row_parity
`endif
);

    localparam int ROW_W = NUM_QUBIT * LIT_W;
    localparam int SP_W  = $clog2(COF_DEPTH + 1);
    localparam int IDX_W = (COF_DEPTH > 1) ? $clog2(COF_DEPTH) : 1;

    localparam logic [2:0] OP_SHIFT_DOWN = 3'd1;
    localparam logic [2:0] OP_ROT_LIT    = 3'd2;
    localparam logic [2:0] OP_SHIFT_PH   = 3'd3;
    localparam logic [2:0] OP_ROT_ROW    = 3'd4;
    localparam logic [2:0] OP_CLEAR      = 3'd5;

    typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_DONE} state_t;

    state_t           state_q;
    logic [2:0]       op_q;
    logic [CNT_W-1:0] rem_q;
    logic             done_q;
    logic             ready_q;
    logic             step_en;

    logic [ROW_W-1:0]      lit_q [NUM_QUBIT];
    logic [MAX_VECTOR-1:0] ph_q  [NUM_QUBIT];
    logic [ROW_W-1:0]      lit_d [NUM_QUBIT];
    logic [MAX_VECTOR-1:0] ph_d  [NUM_QUBIT];

    // Sequencer: only the multi-step ops honour cmd_cnt; everything else is a single step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= 3'd0;
            rem_q   <= '0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (cmd_valid && ready_q) begin
                        op_q    <= cmd_op;
                        rem_q   <= (cmd_op == OP_ROT_LIT || cmd_op == OP_SHIFT_PH ||
                                    cmd_op == OP_ROT_ROW) ? cmd_cnt : CNT_W'(1);
                        ready_q <= 1'b0;
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (rem_q != '0)
                        rem_q <= rem_q - CNT_W'(1);
                    if (rem_q <= CNT_W'(1)) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign step_en   = (state_q == ST_EXEC) && (rem_q != '0);
    assign cmd_ready = ready_q;
    assign done      = done_q;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_QUBIT; gi++) begin : g_row
            // Row above this one; row 0 wraps to the bottom row for ROT_ROW.
            localparam int PREV = (gi == 0) ? NUM_QUBIT - 1 : gi - 1;
            logic [ROW_W-1:0]      down_lit;
            logic [MAX_VECTOR-1:0] down_ph;
            logic [ROW_W-1:0]      row_lit;
            logic [MAX_VECTOR-1:0] row_ph;

            if (gi == 0) begin : g_first
                assign down_lit = literals_in;
                assign down_ph  = phase_in;
            end else begin : g_rest
                assign down_lit = lit_q[PREV];
                assign down_ph  = ph_q[PREV];
            end

            always_comb begin
                row_lit = lit_q[gi];
                row_ph  = ph_q[gi];
                if (step_en) begin
                    unique case (op_q)
                        OP_SHIFT_DOWN: begin
                            row_lit = down_lit;
                            row_ph  = down_ph;
                        end
                        OP_ROT_LIT:  row_lit = {lit_q[gi][LIT_W-1:0], lit_q[gi][ROW_W-1:LIT_W]};
                        OP_SHIFT_PH: row_ph  = {phase_right_in[gi], ph_q[gi][MAX_VECTOR-1:1]};
                        OP_ROT_ROW: begin
                            row_lit = lit_q[PREV];
                            row_ph  = ph_q[PREV];
                        end
                        OP_CLEAR: begin
                            row_lit = '0;
                            row_ph  = '0;
                        end
                        default: ;
                    endcase
                end
            end

            assign lit_d[gi]          = row_lit;
            assign ph_d[gi]           = row_ph;
            assign phase_left_out[gi] = ph_q[gi][0];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_QUBIT; r++) begin
                lit_q[r] <= '0;
                ph_q[r]  <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_QUBIT; r++) begin
                lit_q[r] <= lit_d[r];
                ph_q[r]  <= ph_d[r];
            end
        end
    end

    assign literals_out = lit_q[NUM_QUBIT-1];
    assign phase_out    = ph_q[NUM_QUBIT-1];

    // Cofactor stack: free-running, independent of the sequencer.
    logic [31:0]     stk_q [COF_DEPTH];
    logic [SP_W-1:0] sp_q;
    logic            err_q;
    logic [IDX_W-1:0] top_idx;
    logic [IDX_W-1:0] push_idx;

    assign top_idx   = IDX_W'(sp_q - SP_W'(1));
    assign push_idx  = IDX_W'(sp_q);
    assign cof_empty = (sp_q == '0);
    assign cof_full  = (sp_q == SP_W'(COF_DEPTH));
    assign cof_top   = cof_empty ? 32'd0 : stk_q[top_idx];
    assign cof_err   = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < COF_DEPTH; i++)
                stk_q[i] <= '0;
            sp_q  <= '0;
            err_q <= 1'b0;
        end else if (cof_push && cof_pop && !cof_empty) begin
            stk_q[top_idx] <= cof_pos_in;
        end else if (cof_push) begin
            if (cof_full) begin
                err_q <= 1'b1;
            end else begin
                stk_q[push_idx] <= cof_pos_in;
                sp_q            <= sp_q + SP_W'(1);
            end
        end else if (cof_pop) begin
            if (cof_empty)
                err_q <= 1'b1;
            else
                sp_q <= sp_q - SP_W'(1);
        end
    end

`ifdef STAB_ROW_PARITY_EN
    logic [NUM_QUBIT-1:0] parity_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_q <= '0;
        end else begin
            for (int r = 0; r < NUM_QUBIT; r++)
                parity_q[r] <= ^ph_q[r];
        end
    end

    assign row_parity = parity_q;
`endif

endmodule

// File: tb/tb_register_array_stabilizer_seq.sv
// Self-checking bench for register_array_stabilizer_seq: directed plan plus random commands
// and random stack traffic against an element-level matrix model and a queue-based stack model.
module tb_register_array_stabilizer_seq;

    localparam int NQ     = 4;
    localparam int MV     = 16;
    localparam int LW     = 2;
    localparam int CDEPTH = 4;
    localparam int CW     = 5;
    localparam int ROW_W  = NQ * LW;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [2:0]       cmd_op = '0;
    logic [CW-1:0]    cmd_cnt = '0;
    logic [ROW_W-1:0] literals_in = '0;
    logic [MV-1:0]    phase_in = '0;
    logic [NQ-1:0]    phase_right_in = '0;
    logic [ROW_W-1:0] literals_out;
    logic [MV-1:0]    phase_out;
    logic [NQ-1:0]    phase_left_out;
    logic             done;
    logic             cof_push = 1'b0;
    logic             cof_pop = 1'b0;
    logic [31:0]      cof_pos_in = '0;
    logic [31:0]      cof_top;
    logic             cof_empty;
    logic             cof_full;
    logic             cof_err;

    register_array_stabilizer_seq #(
        .NUM_QUBIT(NQ), .MAX_VECTOR(MV), .LIT_W(LW), .COF_DEPTH(CDEPTH), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_cnt(cmd_cnt),
        .literals_in(literals_in), .phase_in(phase_in), .phase_right_in(phase_right_in),
        .literals_out(literals_out), .phase_out(phase_out), .phase_left_out(phase_left_out),
        .done(done),
        .cof_push(cof_push), .cof_pop(cof_pop), .cof_pos_in(cof_pos_in),
        .cof_top(cof_top), .cof_empty(cof_empty), .cof_full(cof_full), .cof_err(cof_err)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference matrix: literal [row][col] and phase [row][bit].
    logic [LW-1:0] m_lit [NQ][NQ];
    bit            m_ph  [NQ][MV];
    int unsigned   m_stk [$];
    bit            m_err;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int r = 0; r < NQ; r++) begin
            for (int c = 0; c < NQ; c++) m_lit[r][c] = '0;
            for (int j = 0; j < MV; j++) m_ph[r][j] = 1'b0;
        end
    endtask

    function automatic logic [ROW_W-1:0] exp_lit();
        logic [ROW_W-1:0] v;
        for (int c = 0; c < NQ; c++) v[c*LW +: LW] = m_lit[NQ-1][c];
        return v;
    endfunction

    function automatic logic [MV-1:0] exp_ph();
        logic [MV-1:0] v;
        for (int j = 0; j < MV; j++) v[j] = m_ph[NQ-1][j];
        return v;
    endfunction

    function automatic logic [NQ-1:0] exp_left();
        logic [NQ-1:0] v;
        for (int r = 0; r < NQ; r++) v[r] = m_ph[r][0];
        return v;
    endfunction

    task automatic copy_row(input int dst, input int src);
        for (int c = 0; c < NQ; c++) m_lit[dst][c] = m_lit[src][c];
        for (int j = 0; j < MV; j++) m_ph[dst][j] = m_ph[src][j];
    endtask

    task automatic apply_step(input logic [2:0] op, input logic [ROW_W-1:0] lit,
                              input logic [MV-1:0] ph, input logic [NQ-1:0] pr);
        logic [LW-1:0] tl;
        logic [LW-1:0] save_lit [NQ];
        bit            save_ph  [MV];
        case (op)
            3'd1: begin
                for (int r = NQ-1; r > 0; r--) copy_row(r, r-1);
                for (int c = 0; c < NQ; c++) m_lit[0][c] = lit[c*LW +: LW];
                for (int j = 0; j < MV; j++) m_ph[0][j] = ph[j];
            end
            3'd2: for (int r = 0; r < NQ; r++) begin
                tl = m_lit[r][0];
                for (int c = 0; c < NQ-1; c++) m_lit[r][c] = m_lit[r][c+1];
                m_lit[r][NQ-1] = tl;
            end
            3'd3: for (int r = 0; r < NQ; r++) begin
                for (int j = 0; j < MV-1; j++) m_ph[r][j] = m_ph[r][j+1];
                m_ph[r][MV-1] = pr[r];
            end
            3'd4: begin
                for (int c = 0; c < NQ; c++) save_lit[c] = m_lit[NQ-1][c];
                for (int j = 0; j < MV; j++) save_ph[j] = m_ph[NQ-1][j];
                for (int r = NQ-1; r > 0; r--) copy_row(r, r-1);
                for (int c = 0; c < NQ; c++) m_lit[0][c] = save_lit[c];
                for (int j = 0; j < MV; j++) m_ph[0][j] = save_ph[j];
            end
            3'd5: model_clear();
            default: ;
        endcase
    endtask

    task automatic check_matrix(input string tag);
        check({tag, ".lit"},  literals_out,   exp_lit());
        check({tag, ".ph"},   phase_out,      exp_ph());
        check({tag, ".left"}, phase_left_out, exp_left());
    endtask

    // Issue one command, follow it step by step and check latency and handshake.
    task automatic run_cmd(input string tag, input logic [2:0] op, input int cnt,
                           input logic [ROW_W-1:0] lit, input logic [MV-1:0] ph,
                           input bit use_pat, input logic [31:0] pat);
        int steps, exp_lat, cyc;
        steps   = (op == 3'd2 || op == 3'd3 || op == 3'd4) ? cnt : 1;
        exp_lat = ((steps == 0) ? 1 : steps) + 1;
        @(negedge clk);
        check({tag, ".ready_idle"}, cmd_ready, 1'b1);
        cmd_op = op; cmd_cnt = CW'(cnt); literals_in = lit; phase_in = ph;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        // Keep requesting a bogus CLEAR during execution; it must be ignored.
        cmd_op = 3'd5; cmd_cnt = CW'($urandom);
        cyc = 1;
        forever begin
            @(negedge clk);
            check_matrix(tag);
            if (done || cyc >= exp_lat + 3) break;
            check({tag, ".ready_busy"}, cmd_ready, 1'b0);
            phase_right_in = NQ'($urandom);
            if (use_pat && cyc <= steps) phase_right_in[0] = pat[cyc-1];
            if (cyc <= steps) apply_step(op, lit, ph, phase_right_in);
            cyc++;
        end
        cmd_valid = 1'b0;
        check({tag, ".latency"}, cyc, exp_lat);
        check({tag, ".ready_at_done"}, cmd_ready, 1'b0);
        @(negedge clk);
        check({tag, ".done_pulse"}, done, 1'b0);
        check({tag, ".ready_after"}, cmd_ready, 1'b1);
        check_matrix({tag, ".after"});
        $display("cmd %s op=%0d cnt=%0d latency=%0d lit_out=0x%0h ph_out=0x%0h",
                 tag, op, cnt, cyc, literals_out, phase_out);
    endtask

    task automatic stack_op(input string tag, input bit push, input bit pop, input int unsigned val);
        @(negedge clk);
        cof_push = push; cof_pop = pop; cof_pos_in = val;
        @(posedge clk);
        #1;
        cof_push = 1'b0; cof_pop = 1'b0;
        if (push && pop && m_stk.size() > 0) m_stk[m_stk.size()-1] = val;
        else if (push) begin
            if (m_stk.size() == CDEPTH) m_err = 1'b1;
            else m_stk.push_back(val);
        end else if (pop) begin
            if (m_stk.size() == 0) m_err = 1'b1;
            else void'(m_stk.pop_back());
        end
        @(negedge clk);
        check({tag, ".top"},   cof_top,   (m_stk.size() == 0) ? 32'd0 : m_stk[m_stk.size()-1]);
        check({tag, ".empty"}, cof_empty, m_stk.size() == 0);
        check({tag, ".full"},  cof_full,  m_stk.size() == CDEPTH);
        check({tag, ".err"},   cof_err,   m_err);
        $display("stack %s push=%0d pop=%0d val=%0d top=%0d err=%0d", tag, push, pop, val, cof_top, cof_err);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".lit"},   literals_out,   '0);
        check({tag, ".ph"},    phase_out,      '0);
        check({tag, ".left"},  phase_left_out, '0);
        check({tag, ".ready"}, cmd_ready,      1'b1);
        check({tag, ".done"},  done,           1'b0);
        check({tag, ".top"},   cof_top,        32'd0);
        check({tag, ".empty"}, cof_empty,      1'b1);
        check({tag, ".full"},  cof_full,       1'b0);
        check({tag, ".err"},   cof_err,        1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [ROW_W-1:0] lits [4];
        logic [2:0] rop;
        int rcnt;
        bit pu, po;
        lits[0] = 8'h01; lits[1] = 8'h23; lits[2] = 8'h45; lits[3] = 8'h67;
        model_clear();
        m_err = 1'b0;

        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++)
            run_cmd($sformatf("shdn%0d", i), 3'd1, $urandom_range(0, 31), lits[i],
                    (i == 0) ? 16'hA5A5 : MV'($urandom), 1'b0, 0);
        check("plan.bottom_lit", literals_out, 8'h01);
        check("plan.bottom_ph",  phase_out,    16'hA5A5);

        run_cmd("rotlit5", 3'd2, 5, '0, '0, 1'b0, 0);
        check("plan.rotlit_net1", literals_out, 8'h40);

        run_cmd("shph3", 3'd3, 3, '0, '0, 1'b1, 32'b101);
        run_cmd("rotrow3", 3'd4, NQ-1, '0, '0, 1'b0, 0);
        check("plan.row0_top3", phase_out[MV-1:MV-3], 3'b101);
        run_cmd("rotrow1", 3'd4, 1, '0, '0, 1'b0, 0);
        run_cmd("rotrowN", 3'd4, NQ, '0, '0, 1'b0, 0);
        run_cmd("rotrow0", 3'd4, 0, '0, '0, 1'b0, 0);
        run_cmd("rotlit0", 3'd2, 0, '0, '0, 1'b0, 0);
        run_cmd("nop0", 3'd0, 7, '1, '1, 1'b0, 0);
        run_cmd("nop6", 3'd6, 3, '1, '1, 1'b0, 0);
        run_cmd("nop7", 3'd7, 9, '1, '1, 1'b0, 0);
        run_cmd("clear", 3'd5, 4, '1, '1, 1'b0, 0);

        for (int i = 0; i < 30; i++) begin
            rop  = 3'($urandom_range(0, 7));
            rcnt = $urandom_range(0, 20);
            if (rop == 3'd5 && ($urandom_range(0, 3) != 0)) rop = 3'd1;
            run_cmd($sformatf("rnd%0d", i), rop, rcnt, ROW_W'($urandom), MV'($urandom), 1'b0, 0);
        end

        stack_op("pp_empty", 1'b1, 1'b1, 7);
        stack_op("pp_replace", 1'b1, 1'b1, 9);
        stack_op("pop_one", 1'b0, 1'b1, 0);
        stack_op("push10", 1'b1, 1'b0, 10);
        stack_op("push20", 1'b1, 1'b0, 20);
        stack_op("push30", 1'b1, 1'b0, 30);
        stack_op("push40", 1'b1, 1'b0, 40);
        stack_op("push50_full", 1'b1, 1'b0, 50);
        stack_op("pp_full", 1'b1, 1'b1, 45);
        for (int i = 0; i < 4; i++) stack_op($sformatf("pop%0d", i), 1'b0, 1'b1, 0);
        stack_op("pop_empty", 1'b0, 1'b1, 0);
        for (int i = 0; i < 20; i++) begin
            pu = 1'($urandom); po = 1'($urandom);
            stack_op($sformatf("srnd%0d", i), pu, po, $urandom_range(1, 1000));
        end
        stack_op("push_pre_rst", 1'b1, 1'b0, 77);

        // Reset in the middle of a long ROT_LIT.
        @(negedge clk);
        cmd_op = 3'd2; cmd_cnt = CW'(10); cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_reset_state("async_rst");
        model_clear();
        m_stk.delete();
        m_err = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("rst_hold_done%0d", i), done, 1'b0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst.done", done, 1'b0);
        check_reset_state("post_rst");
        run_cmd("recover", 3'd1, 0, 8'hC3, 16'h1234, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
